// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic light timebase.
// Seconds width, timer thresholds and the button debounce state set.
package traffic_pkg;

    localparam int SEC_W = 6;

    localparam logic [SEC_W-1:0] T5      = 6'd5;
    localparam logic [SEC_W-1:0] T15     = 6'd15;
    localparam logic [SEC_W-1:0] T20     = 6'd20;
    localparam logic [SEC_W-1:0] T50     = 6'd50;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd63;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pedestrian button synchronizer and debounce filter.
// Emits one press pulse per accepted press; DB_CYCLES must be >= 2.
module btn_debounce
    import traffic_pkg::*;
#(
    parameter int DB_CYCLES = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    db_state_e       r_state;
    db_state_e       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_in;
    logic            w_press;

    assign w_in    = r_sync2;
    assign o_press = w_press;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce state and stable-run counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: the leaving cycle of IDLE/HELD counts as the first
    // stable cycle, so the wait states finish at DB_CYCLES-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        unique case (r_state)
            DB_IDLE: begin
                if (w_in) begin
                    w_state_nxt = DB_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!w_in) begin
                    w_state_nxt = DB_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_HELD;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DB_HELD: begin
                if (!w_in) begin
                    w_state_nxt = DB_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (w_in) begin
                    w_state_nxt = DB_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = DB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/traffic_timebase.sv
// One-second timebase, seconds counter, threshold decode and
// pedestrian request latch for the traffic light controller.
module traffic_timebase
    import traffic_pkg::*;
#(
    parameter int CLK_HZ    = 125000000,
    parameter int DB_CYCLES = 2500000
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             zc,
    input  logic             req_ack,
    output logic             tick,
    output logic             bt,
    output logic [SEC_W-1:0] sec_cnt,
    output logic             t5s,
    output logic             t15s,
    output logic             t20s,
    output logic             t50s
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] r_presc;
    logic [SEC_W-1:0] r_sec;
    logic             r_bt;
    logic             w_tick;
    logic             w_press;

    assign w_tick  = (r_presc == PRE_LAST);
    assign tick    = w_tick;
    assign bt      = r_bt;
    assign sec_cnt = r_sec;
    assign t5s     = (r_sec == T5);
    assign t15s    = (r_sec == T15);
    assign t20s    = (r_sec == T20);
    assign t50s    = (r_sec == T50);

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .i_clk     (sysclk),
        .i_rst_n   (rst_n),
        .i_btn_raw (btn_raw),
        .o_press   (w_press)
    );

    // Prescaler wraps at CLK_HZ-1; its terminal count is the tick enable.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Seconds counter: clear or saturating increment on tick only.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec <= '0;
        end else if (w_tick) begin
            if (zc) begin
                r_sec <= '0;
            end else if (r_sec != SEC_MAX) begin
                r_sec <= r_sec + 1'b1;
            end
        end
    end

    // Request latch: a new press outranks a same-cycle acknowledge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bt <= 1'b0;
        end else if (w_press) begin
            r_bt <= 1'b1;
        end else if (req_ack) begin
            r_bt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_timebase.sv
// Bench for traffic_timebase with a behavioural reference model.
// Directed scenarios followed by a randomized run.
module tb_traffic_timebase;

    localparam int CLK = 10;
    localparam int DB  = 4;

    logic       sysclk;
    logic       rst_n;
    logic       btn_raw;
    logic       zc;
    logic       req_ack;
    logic       tick;
    logic       bt;
    logic [5:0] sec_cnt;
    logic       t5s;
    logic       t15s;
    logic       t20s;
    logic       t50s;

    int n_vec;
    int n_bad;

    // reference model state
    int   m_presc;
    int   m_sec;
    logic m_bt;
    logic m_s1;
    logic m_s2;
    logic m_lvl;
    int   m_run;

    traffic_timebase #(
        .CLK_HZ    (CLK),
        .DB_CYCLES (DB)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .zc      (zc),
        .req_ack (req_ack),
        .tick    (tick),
        .bt      (bt),
        .sec_cnt (sec_cnt),
        .t5s     (t5s),
        .t15s    (t15s),
        .t20s    (t20s),
        .t50s    (t50s)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    function automatic logic [11:0] dut_vec();
        return {tick, bt, sec_cnt, t5s, t15s, t20s, t50s};
    endfunction

    function automatic logic [11:0] mdl_vec();
        logic [5:0] s;
        s = 6'(m_sec);
        return {m_presc == CLK - 1, m_bt, s,
                m_sec == 5, m_sec == 15, m_sec == 20, m_sec == 50};
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_sec   = 0;
        m_bt    = 1'b0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_lvl   = 1'b0;
        m_run   = 0;
    endtask

    // One clock edge of the reference: the debounced level flips after
    // DB consecutive synchronized samples that disagree with it.
    task automatic model_edge(input logic raw, input logic z,
                              input logic a);
        logic s;
        logic press;
        logic tk;
        s     = m_s2;
        press = 1'b0;
        if (s == m_lvl) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DB) begin
                m_lvl = ~m_lvl;
                m_run = 0;
                press = m_lvl;
            end
        end
        m_bt = press | (m_bt & ~a);
        m_s2 = m_s1;
        m_s1 = raw;
        tk   = (m_presc == CLK - 1);
        if (tk) begin
            if (z) m_sec = 0;
            else if (m_sec < 63) m_sec = m_sec + 1;
        end
        m_presc = tk ? 0 : m_presc + 1;
    endtask

    task automatic step(input logic raw, input logic z, input logic a);
        btn_raw = raw;
        zc      = z;
        req_ack = a;
        @(posedge sysclk);
        model_edge(raw, z, a);
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        zc      = 1'b0;
        req_ack = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            btn_raw = i[0];
            n_vec++;
            if (dut_vec() !== 12'h000) begin
                n_bad++;
                $display("FAIL reset_hold: got %h want %h",
                         dut_vec(), 12'h000);
            end
        end
        btn_raw = 1'b0;
        rst_n   = 1'b1;
        n_vec++;
        if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h",
                     dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_seconds();
        int ticks;
        int t5n;
        int t50n;
        ticks = 0;
        t5n   = 0;
        t50n  = 0;
        for (int i = 0; i < 640; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL seconds cyc %0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
            if (tick) ticks++;
            if (t5s) t5n++;
            if (t50s) t50n++;
        end
        n_vec++;
        if (ticks !== 64) begin
            n_bad++;
            $display("FAIL tick_count: got %0d want 64", ticks);
        end
        n_vec++;
        if (t5n !== 10) begin
            n_bad++;
            $display("FAIL t5s_width: got %0d want 10", t5n);
        end
        n_vec++;
        if (t50n !== 10) begin
            n_bad++;
            $display("FAIL t50s_width: got %0d want 10", t50n);
        end
        n_vec++;
        if (sec_cnt !== 6'd63) begin
            n_bad++;
            $display("FAIL saturate: got %0d want 63", sec_cnt);
        end
    endtask

    task automatic test_zc();
        int keep;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (m_sec == 17 && m_presc == 5) break;
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL zc_run: got %h want %h",
                         dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (sec_cnt !== 6'd17) begin
            n_bad++;
            $display("FAIL zc_pre: got %0d want 17", sec_cnt);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (sec_cnt !== 6'd0) begin
            n_bad++;
            $display("FAIL zc_clear: got %0d want 0", sec_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            if (m_sec >= 2 && m_presc == 3) break;
            step(1'b0, 1'b0, 1'b0);
        end
        keep = m_sec;
        step(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (sec_cnt !== 6'(keep)) begin
            n_bad++;
            $display("FAIL zc_between: got %0d want %0d", sec_cnt, keep);
        end
    endtask

    task automatic test_bounce();
        int rise;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(((i >> 1) & 1) == 0, 1'b0, 1'b0);
            n_vec++;
            if (bt !== 1'b0) begin
                n_bad++;
                $display("FAIL bounce_bt cyc %0d: got %b want 0", i, bt);
            end
        end
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bt === 1'b1 && rise < 0) rise = i;
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL bounce_run cyc %0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (rise !== DB + 1) begin
            n_bad++;
            $display("FAIL press_latency: got %0d want %0d", rise, DB + 1);
        end
    endtask

    task automatic test_held_ack();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, i == 50);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL held cyc %0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (bt !== 1'b0) begin
            n_bad++;
            $display("FAIL held_no_repeat: got %b want 0", bt);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bt !== 1'b0) begin
            n_bad++;
            $display("FAIL release_bt: got %b want 0", bt);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (bt !== 1'b1) begin
            n_bad++;
            $display("FAIL repress_bt: got %b want 1", bt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, i == DB + 1);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL coincide cyc %0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
        end
        n_vec++;
        if (bt !== 1'b1) begin
            n_bad++;
            $display("FAIL coincide_bt: got %b want 1", bt);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (m_sec == 30 && m_presc == 2) break;
            step(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL pre_reset: got %h want %h",
                     dut_vec(), mdl_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== 12'h000) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h",
                     dut_vec(), 12'h000);
        end
        model_reset();
        @(negedge sysclk);
        @(negedge sysclk);
        btn_raw = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL post_reset cyc %0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        logic raw;
        int   len;
        raw = 1'b0;
        len = 0;
        for (int i = 0; i < 3000; i++) begin
            if (len == 0) begin
                raw = ~raw;
                len = $urandom_range(1, 12);
            end
            len--;
            step(raw, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 19) == 0);
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_seconds();
        test_zc();
        test_bounce();
        test_held_ack();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
